// File: rtl/writeback_skid_stage.sv
// Execute-to-writeback register stage with a two-entry skid buffer, flush,
// optional squashing of register-0 writes and a forwarding lookup over in-flight entries.
module writeback_skid_stage #(
  parameter int WIDTH           = 8,
  parameter int REG_AW          = 5,
  parameter bit ZERO_REG_SQUASH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_wen,
  input  logic [REG_AW-1:0] in_wr_reg,
  input  logic [WIDTH-1:0]  in_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_wen,
  output logic [REG_AW-1:0] out_wr_reg,
  output logic [WIDTH-1:0]  out_result,
  input  logic [REG_AW-1:0] fwd_rd_reg,
  output logic              fwd_hit,
  output logic [WIDTH-1:0]  fwd_data
);

  typedef struct packed {
    logic              wen;
    logic [REG_AW-1:0] wr_reg;
    logic [WIDTH-1:0]  result;
  } entry_t;

  // Occupancy doubles as the valid bits: main is valid unless EMPTY, skid only in FULL.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic pop;
  logic squash;

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_FULL);

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready = !skid_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid & out_ready;

  assign squash          = ZERO_REG_SQUASH && (in_wr_reg == '0);
  assign in_entry.wen    = in_reg_wen & !squash;
  assign in_entry.wr_reg = in_wr_reg;
  assign in_entry.result = in_result;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the data fields are reset too, because out_wr_reg/out_result must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_valid   = main_valid;
  assign out_reg_wen = main_valid & main_q.wen;
  assign out_wr_reg  = main_q.wr_reg;
  assign out_result  = main_q.result;

  // Skid holds the younger bundle, so its match overrides main's.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (main_valid && main_q.wen && (main_q.wr_reg == fwd_rd_reg)) begin
      fwd_hit  = 1'b1;
      fwd_data = main_q.result;
    end
    if (skid_valid && skid_q.wen && (skid_q.wr_reg == fwd_rd_reg)) begin
      fwd_hit  = 1'b1;
      fwd_data = skid_q.result;
    end
  end

endmodule

// File: tb/tb_writeback_skid_stage.sv
// Self-checking bench for writeback_skid_stage: directed scenarios plus randomized
// traffic, compared against a queue-based FIFO reference model.
module tb_writeback_skid_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic       in_reg_wen;
  logic [4:0] in_wr_reg;
  logic [7:0] in_result;
  logic       out_valid;
  logic       out_ready;
  logic       out_reg_wen;
  logic [4:0] out_wr_reg;
  logic [7:0] out_result;
  logic [4:0] fwd_rd_reg;
  logic       fwd_hit;
  logic [7:0] fwd_data;

  writeback_skid_stage #(.WIDTH(8), .REG_AW(5), .ZERO_REG_SQUASH(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_reg_wen (in_reg_wen),
    .in_wr_reg  (in_wr_reg),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_reg_wen(out_reg_wen),
    .out_wr_reg (out_wr_reg),
    .out_result (out_result),
    .fwd_rd_reg (fwd_rd_reg),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wen;
    logic [4:0] r;
    logic [7:0] d;
  } bundle_t;

  bundle_t mq[$];   // in-flight bundles, oldest first, at most two
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic       hit;
    logic [7:0] data;
    check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("out_reg_wen", 32'(out_reg_wen), 32'(mq[0].wen));
      check("out_wr_reg", 32'(out_wr_reg), 32'(mq[0].r));
      check("out_result", 32'(out_result), 32'(mq[0].d));
    end else begin
      check("out_reg_wen_idle", 32'(out_reg_wen), 32'd0);
    end
    hit  = 1'b0;
    data = 8'h00;
    foreach (mq[i]) begin
      if (mq[i].wen && mq[i].r == fwd_rd_reg) begin
        hit  = 1'b1;
        data = mq[i].d;
      end
    end
    check("fwd_hit", 32'(fwd_hit), 32'(hit));
    check("fwd_data", 32'(fwd_data), 32'(data));
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] r, input logic [7:0] d,
                       input logic ordy, input logic fl, input logic [4:0] fr);
    @(negedge clk);
    in_valid   = v;
    in_reg_wen = w;
    in_wr_reg  = r;
    in_result  = d;
    out_ready  = ordy;
    flush      = fl;
    fwd_rd_reg = fr;
    #1;
    compare_model();
  endtask

  task automatic tick();
    logic    acc;
    logic    pop;
    logic    fl;
    bundle_t e;
    acc   = in_valid && (mq.size() < 2);
    pop   = (mq.size() > 0) && out_ready;
    fl    = flush;
    e.wen = in_reg_wen && (in_wr_reg != 5'd0);
    e.r   = in_wr_reg;
    e.d   = in_result;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
  endtask

  task automatic idle(input logic ordy, input logic [4:0] fr);
    drive(1'b0, 1'b0, 5'd0, 8'h00, ordy, 1'b0, fr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_reg_wen"}, 32'(out_reg_wen), 32'd0);
    check({tag, "_out_wr_reg"}, 32'(out_wr_reg), 32'd0);
    check({tag, "_out_result"}, 32'(out_result), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_fwd_hit"}, 32'(fwd_hit), 32'd0);
    check({tag, "_fwd_data"}, 32'(fwd_data), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_reg_wen = 1'b0;
    in_wr_reg  = 5'd0;
    in_result  = 8'h00;
    out_ready  = 1'b0;
    fwd_rd_reg = 5'd0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full-rate stream: each bundle visible the cycle after acceptance.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, 5'(k), 8'(8'h11 * k), 1'b1, 1'b0, 5'd0);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (k > 1) begin
        check("stream_reg", 32'(out_wr_reg), 32'(k - 1));
        check("stream_res", 32'(out_result), 32'(8'h11 * (k - 1)));
        check("stream_wen", 32'(out_reg_wen), 32'd1);
      end
      tick();
    end
    idle(1'b1, 5'd0);
    check("stream_last", 32'(out_result), 32'h44);
    tick();

    // Backpressure fills the skid; third bundle waits upstream.
    drive(1'b1, 1'b1, 5'd5, 8'hA5, 1'b0, 1'b0, 5'd0); tick();
    drive(1'b1, 1'b1, 5'd6, 8'hB6, 1'b0, 1'b0, 5'd0); tick();
    drive(1'b1, 1'b1, 5'd7, 8'hC7, 1'b0, 1'b0, 5'd0);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_head", 32'(out_result), 32'hA5);
    tick();
    drive(1'b1, 1'b1, 5'd7, 8'hC7, 1'b1, 1'b0, 5'd0);
    check("bp_drain0", 32'(out_result), 32'hA5);
    tick();
    drive(1'b1, 1'b1, 5'd7, 8'hC7, 1'b1, 1'b0, 5'd0);
    check("bp_drain1", 32'(out_result), 32'hB6);
    tick();
    idle(1'b1, 5'd0);
    check("bp_drain2", 32'(out_result), 32'hC7);
    tick();
    idle(1'b1, 5'd0);
    check("bp_empty", 32'(out_valid), 32'd0);
    tick();

    // Forwarding picks the younger skid entry.
    drive(1'b1, 1'b1, 5'd5, 8'hA5, 1'b0, 1'b0, 5'd0); tick();
    drive(1'b1, 1'b1, 5'd5, 8'hC3, 1'b0, 1'b0, 5'd0); tick();
    idle(1'b0, 5'd5);
    check("fwd5_hit", 32'(fwd_hit), 32'd1);
    check("fwd5_data", 32'(fwd_data), 32'hC3);
    fwd_rd_reg = 5'd7;
    #1;
    check("fwd7_hit", 32'(fwd_hit), 32'd0);
    check("fwd7_data", 32'(fwd_data), 32'h00);
    tick();

    // Flush while FULL with a simultaneous input.
    drive(1'b1, 1'b1, 5'd6, 8'h66, 1'b0, 1'b1, 5'd0);
    check("flush_ready_same", 32'(in_ready), 32'd0);
    tick();
    idle(1'b1, 5'd6);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    tick();
    idle(1'b1, 5'd6);
    check("flush_gone", 32'(out_valid), 32'd0);
    tick();

    // Register-0 write flows through with wen squashed.
    drive(1'b1, 1'b1, 5'd0, 8'hFF, 1'b0, 1'b0, 5'd0); tick();
    idle(1'b1, 5'd0);
    check("sq_valid", 32'(out_valid), 32'd1);
    check("sq_wen", 32'(out_reg_wen), 32'd0);
    check("sq_fwd", 32'(fwd_hit), 32'd0);
    check("sq_res", 32'(out_result), 32'hFF);
    tick();

    // Asynchronous reset between edges while in ONE.
    drive(1'b1, 1'b1, 5'd3, 8'h3C, 1'b0, 1'b0, 5'd3); tick();
    idle(1'b0, 5'd3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    drive(1'b1, 1'b1, 5'd9, 8'h99, 1'b1, 1'b0, 5'd9); tick();
    idle(1'b1, 5'd9);
    check("post_rst_reg", 32'(out_wr_reg), 32'd9);
    check("post_rst_res", 32'(out_result), 32'h99);
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
            5'($urandom_range(0, 7)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
